regfile_storage: RTL and testbench

//  32-entry x 32-bit register file storage for the single-cycle CPU datapath.

---
 rtl/regfile_storage.sv | 101 ++++++++++
 tb/tb_regfile_storage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/regfile_storage.sv
// 32-entry register file storage with one write port and two mux-based read ports.

// 32-way WIDTH-bit read multiplexer; input0..input31 packed as inputs[0..31].
module mux32to1by32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [4:0]             address,
  input  logic [31:0][WIDTH-1:0] inputs,
  output logic [WIDTH-1:0]       out
);

  // Select one register word by address.
  always_comb begin
    out = inputs[address];
  end

endmodule

module regfile_storage #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          BYPASS   = 1'b0,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             RegWrite,
  input  logic [4:0]       WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  localparam int unsigned NUM_REGS = 32;

  logic [NUM_REGS-1:0][WIDTH-1:0] regs;
  logic [NUM_REGS-1:0][WIDTH-1:0] mux_in;
  logic [NUM_REGS-1:0]            wen;
  logic [WIDTH-1:0]               mux1_out;
  logic [WIDTH-1:0]               mux2_out;
  logic                           fwd1;
  logic                           fwd2;

  // One-hot write decode gated by RegWrite; r0 is never enabled when hardwired.
  always_comb begin
    wen = '0;
    if (RegWrite) begin
      wen[WriteRegister] = 1'b1;
    end
    if (ZERO_REG) begin
      wen[0] = 1'b0;
    end
  end

  // Register storage: reset clears every entry and overrides any write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wen[i]) begin
          regs[i] <= WriteData;
        end
      end
    end
  end

  // Mux feed; r0 forced to zero so it reads 0 even before the first reset.
  always_comb begin
    mux_in = regs;
    if (ZERO_REG) begin
      mux_in[0] = '0;
    end
  end

  mux32to1by32 #(.WIDTH(WIDTH)) u_mux1 (
    .address (ReadRegister1),
    .inputs  (mux_in),
    .out     (mux1_out)
  );

  mux32to1by32 #(.WIDTH(WIDTH)) u_mux2 (
    .address (ReadRegister2),
    .inputs  (mux_in),
    .out     (mux2_out)
  );

  // Same-cycle forwarding; wen already excludes a hardwired r0, Reset suppresses it.
  always_comb begin
    fwd1 = BYPASS && !Reset && wen[ReadRegister1];
    fwd2 = BYPASS && !Reset && wen[ReadRegister2];
  end

  // Read port outputs.
  always_comb begin
    ReadData1 = fwd1 ? WriteData : mux1_out;
    ReadData2 = fwd2 ? WriteData : mux2_out;
  end

endmodule

// File: tb/tb_regfile_storage.sv
// Scoreboard bench for regfile_storage: instance a (BYPASS=0, ZERO_REG=1), instance b (BYPASS=1, ZERO_REG=0).
module tb_regfile_storage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 Clk = ~Clk;

  regfile_storage #(.WIDTH(32), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_dut_a (
    .Clk(Clk), .Reset(Reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(rd1_a), .ReadData2(rd2_a)
  );

  regfile_storage #(.WIDTH(32), .BYPASS(1'b1), .ZERO_REG(1'b0)) u_dut_b (
    .Clk(Clk), .Reset(Reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(rd1_b), .ReadData2(rd2_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_a(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'h0 : mem_a[idx];
  endfunction

  function automatic logic [31:0] exp_b(input logic [4:0] idx);
    if (RegWrite && !Reset && WriteRegister == idx) return WriteData;
    return mem_b[idx];
  endfunction

  // Advance one rising edge, updating the reference models from the pre-edge inputs.
  task automatic tick();
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        mem_a[i] = 32'h0;
        mem_b[i] = 32'h0;
      end
    end else if (RegWrite) begin
      if (WriteRegister != 5'd0) mem_a[WriteRegister] = WriteData;
      mem_b[WriteRegister] = WriteData;
    end
    @(posedge Clk);
    #1;
  endtask

  // Drive read addresses, push expectations, then pop and compare against the DUT.
  task automatic read_check(input string tag, input logic [4:0] r1, input logic [4:0] r2);
    exp_t e;
    ReadRegister1 = r1;
    ReadRegister2 = r2;
    sb_q.push_back('{tag: {tag, " a.rd1"}, val: exp_a(r1)});
    sb_q.push_back('{tag: {tag, " a.rd2"}, val: exp_a(r2)});
    sb_q.push_back('{tag: {tag, " b.rd1"}, val: exp_b(r1)});
    sb_q.push_back('{tag: {tag, " b.rd2"}, val: exp_b(r2)});
    #1;
    e = sb_q.pop_front(); check($sformatf("%s r%0d", e.tag, r1), rd1_a, e.val);
    e = sb_q.pop_front(); check($sformatf("%s r%0d", e.tag, r2), rd2_a, e.val);
    e = sb_q.pop_front(); check($sformatf("%s r%0d", e.tag, r1), rd1_b, e.val);
    e = sb_q.pop_front(); check($sformatf("%s r%0d", e.tag, r2), rd2_b, e.val);
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [31:0] data);
    RegWrite      = 1'b1;
    WriteRegister = idx;
    WriteData     = data;
    tick();
    RegWrite      = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;
    #2;
    tick();
    Reset = 1'b0;

    // Everything reads zero after reset
    for (int i = 0; i < 32; i++) read_check("reset", 5'(i), 5'(31 - i));

    // Basic writes
    write_reg(5'd5, 32'hDEADBEEF);
    write_reg(5'd31, 32'h12345678);
    read_check("basic", 5'd5, 5'd31);
    read_check("untouched", 5'd6, 5'd6);

    // r0 write: discarded on a, stored on b
    write_reg(5'd0, 32'hFFFFFFFF);
    read_check("r0", 5'd0, 5'd0);

    // Disabled write leaves r7 unchanged
    WriteRegister = 5'd7; WriteData = 32'hAAAA5555;
    tick();
    read_check("nowrite", 5'd7, 5'd7);

    // Walking write through r1..r31 with unique data, then read all back
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'hA5000000 | (32'(i) << 8) | 32'(i));
    for (int i = 0; i < 32; i++) read_check("walk", 5'(i), 5'((i + 7) % 32));

    // Reset has priority over a same-edge write; full clear
    Reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 32'h1;
    tick();
    Reset = 1'b0; RegWrite = 1'b0;
    read_check("rst_prio", 5'd9, 5'd31);
    read_check("rst_clear", 5'd17, 5'd1);

    // Same-cycle read while writing r3
    RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 32'hCAFEF00D;
    read_check("bypass_pre", 5'd3, 5'd3);
    tick();
    RegWrite = 1'b0;
    read_check("bypass_post", 5'd3, 5'd3);

    // Forwarding suppressed during reset
    Reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 32'h0BADF00D;
    read_check("bypass_rst", 5'd3, 5'd4);
    tick();
    Reset = 1'b0; RegWrite = 1'b0;

    // Forwarding to r0 only where r0 is ordinary storage
    RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 32'h13572468;
    read_check("bypass_r0", 5'd0, 5'd1);
    tick();
    RegWrite = 1'b0;

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      Reset         = ($urandom_range(0, 39) == 0);
      RegWrite      = $urandom_range(0, 1) == 1;
      WriteRegister = 5'($urandom_range(0, 31));
      WriteData     = $urandom;
      if ($urandom_range(0, 3) == 0) read_check("rand", WriteRegister, 5'($urandom_range(0, 31)));
      else read_check("rand", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      tick();
    end
    Reset = 1'b0; RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) read_check("final", 5'(i), 5'(31 - i));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
